// File: rtl/rally_ctrl.sv
// Rally controller for a two-player volleyball-style game.
// Tracks touches per side, ghost-time filtering of collision edges, ground
// point awards, the post-point pause and match end. All outputs registered.
module rally_ctrl #(
  parameter int MAX_TOUCH   = 3,
  parameter int WIN_SCORE   = 15,
  parameter int NET_X       = 512,
  parameter int BALL_HALF   = 32,
  parameter int GHOST_TICKS = 18,
  parameter int WAIT_TICKS  = 250
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        start,
  input  logic        pl1_col,
  input  logic        pl2_col,
  input  logic        gnd_col,
  input  logic [11:0] ball_posx,
  output logic        last_touch,
  output logic        ovr_touch,
  output logic [3:0]  score1,
  output logic [3:0]  score2,
  output logic        game_over,
  output logic        winner,
  output logic [2:0]  rally_state
);

  localparam int CW = $clog2(MAX_TOUCH + 2);
  localparam int GW = (GHOST_TICKS < 1) ? 1 : $clog2(GHOST_TICKS + 1);
  localparam int WW = (WAIT_TICKS < 2) ? 1 : $clog2(WAIT_TICKS + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    RALLY = 3'd2,
    POINT = 3'd3,
    OVER  = 3'd4
  } state_t;

  state_t          state;
  logic            pl1_q;
  logic            pl2_q;
  logic [CW-1:0]   cnt1;
  logic [CW-1:0]   cnt2;
  logic [GW-1:0]   ghost_cnt;
  logic [WW-1:0]   wait_cnt;

  logic            rise1;
  logic            rise2;
  logic            ghost_ok;
  logic            touch;
  logic            toucher;
  logic [12:0]     gnd_sum;
  logic            near_p1;
  logic            same_side;
  logic [CW-1:0]   next_cnt;
  logic            over_hit;
  logic            pt_award;
  logic            pt_to;

  // Score increment that holds at the winning score.
  function automatic logic [3:0] sat_inc(input logic [3:0] s);
    if (s >= 4'(WIN_SCORE)) return s;
    return s + 4'd1;
  endfunction

  assign rally_state = state;

  // Touch qualification, ground-side decision and point-award conditions.
  always_comb begin
    rise1     = pl1_col & ~pl1_q;
    rise2     = pl2_col & ~pl2_q;
    ghost_ok  = (ghost_cnt >= GW'(GHOST_TICKS)) || (state == SERVE);
    // Player 1 takes priority when both edges land in the same clock.
    touch     = (rise1 | rise2) & ghost_ok;
    toucher   = ~rise1;
    // 13-bit sum so a ball near the right edge cannot wrap onto player 1's side.
    gnd_sum   = {1'b0, ball_posx} + 13'(BALL_HALF);
    near_p1   = gnd_sum < 13'(NET_X);
    same_side = touch && (toucher == last_touch);
    next_cnt  = (toucher ? cnt2 : cnt1) + CW'(1);
    over_hit  = same_side && (next_cnt == CW'(MAX_TOUCH + 1));
    pt_award  = (state == RALLY) && (gnd_col || over_hit);
    // pt_to: 1 = player 2 scores. Ground on player 1's half goes to player 2.
    pt_to     = gnd_col ? near_p1 : ~toucher;
  end

  // Match FSM with registered outputs, touch counters and tick counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      score1     <= '0;
      score2     <= '0;
      last_touch <= 1'b0;
      ovr_touch  <= 1'b0;
      game_over  <= 1'b0;
      winner     <= 1'b0;
      cnt1       <= '0;
      cnt2       <= '0;
      ghost_cnt  <= '0;
      wait_cnt   <= '0;
      pl1_q      <= 1'b0;
      pl2_q      <= 1'b0;
    end else begin
      pl1_q     <= pl1_col;
      pl2_q     <= pl2_col;
      ovr_touch <= 1'b0;
      if (tick && (ghost_cnt < GW'(GHOST_TICKS)))
        ghost_cnt <= ghost_cnt + GW'(1);

      case (state)
        IDLE: begin
          if (start) begin
            score1     <= '0;
            score2     <= '0;
            last_touch <= 1'b0;
            cnt1       <= '0;
            cnt2       <= '0;
            ghost_cnt  <= '0;
            state      <= SERVE;
          end
        end

        SERVE: begin
          // Ground contact is meaningless before the serve is struck.
          if (touch) begin
            last_touch <= toucher;
            cnt1       <= toucher ? CW'(0) : CW'(1);
            cnt2       <= toucher ? CW'(1) : CW'(0);
            ghost_cnt  <= '0;
            state      <= RALLY;
          end
        end

        RALLY: begin
          if (pt_award) begin
            if (pt_to) score2 <= sat_inc(score2);
            else       score1 <= sat_inc(score1);
            last_touch <= pt_to;
            ovr_touch  <= ~gnd_col;
            wait_cnt   <= '0;
            state      <= POINT;
          end else if (touch) begin
            ghost_cnt <= '0;
            if (same_side) begin
              if (toucher) cnt2 <= next_cnt;
              else         cnt1 <= next_cnt;
            end else begin
              last_touch <= toucher;
              cnt1       <= toucher ? CW'(0) : CW'(1);
              cnt2       <= toucher ? CW'(1) : CW'(0);
            end
          end
        end

        POINT: begin
          if (tick) begin
            if (wait_cnt == WW'(WAIT_TICKS - 1)) begin
              if ((score1 == 4'(WIN_SCORE)) || (score2 == 4'(WIN_SCORE))) begin
                game_over <= 1'b1;
                winner    <= (score2 == 4'(WIN_SCORE));
                state     <= OVER;
              end else begin
                cnt1      <= '0;
                cnt2      <= '0;
                ghost_cnt <= '0;
                state     <= SERVE;
              end
            end else begin
              wait_cnt <= wait_cnt + WW'(1);
            end
          end
        end

        OVER: begin
          if (start) begin
            score1     <= '0;
            score2     <= '0;
            last_touch <= ~winner;
            game_over  <= 1'b0;
            cnt1       <= '0;
            cnt2       <= '0;
            ghost_cnt  <= '0;
            state      <= SERVE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rally_ctrl.sv
// Testbench for rally_ctrl: table of ground-contact positions plus hand-built
// sequences for touch limits, ghost time, priority, match end and reset.
module tb_rally_ctrl;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SERVE = 3'd1;
  localparam logic [2:0] S_RALLY = 3'd2;
  localparam logic [2:0] S_POINT = 3'd3;
  localparam logic [2:0] S_OVER  = 3'd4;

  logic        clk = 1'b0;
  logic        rst;
  logic        tick;
  logic        start;
  logic        pl1_col;
  logic        pl2_col;
  logic        gnd_col;
  logic [11:0] ball_posx;
  logic        last_touch;
  logic        ovr_touch;
  logic [3:0]  score1;
  logic [3:0]  score2;
  logic        game_over;
  logic        winner;
  logic [2:0]  rally_state;

  rally_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .tick        (tick),
    .start       (start),
    .pl1_col     (pl1_col),
    .pl2_col     (pl2_col),
    .gnd_col     (gnd_col),
    .ball_posx   (ball_posx),
    .last_touch  (last_touch),
    .ovr_touch   (ovr_touch),
    .score1      (score1),
    .score2      (score2),
    .game_over   (game_over),
    .winner      (winner),
    .rally_state (rally_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [2:0] st;
    logic [3:0] s1;
    logic [3:0] s2;
    logic       lt;
    logic       ovr;
    logic       go;
    logic       win;
  } exp_t;

  typedef struct {
    logic [11:0] posx;
    logic        p2_scores;
  } vec_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  logic [3:0] m_s1;
  logic [3:0] m_s2;
  logic       m_lt;
  logic       m_go;
  logic       m_win;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    tick = 1'b1;
    repeat (n) cyc();
    tick = 1'b0;
  endtask

  task automatic compare_out();
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got no expected record");
    end else begin
      e = sb.pop_front();
      if (rally_state !== e.st || score1 !== e.s1 || score2 !== e.s2 ||
          last_touch !== e.lt || ovr_touch !== e.ovr || game_over !== e.go ||
          winner !== e.win) begin
        errors++;
        $display("FAIL %s: got st=%0d s1=%0d s2=%0d lt=%0b ovr=%0b go=%0b win=%0b, expected st=%0d s1=%0d s2=%0d lt=%0b ovr=%0b go=%0b win=%0b",
                 e.name, rally_state, score1, score2, last_touch, ovr_touch,
                 game_over, winner, e.st, e.s1, e.s2, e.lt, e.ovr, e.go, e.win);
      end
    end
  endtask

  // Push the expectation for the clock about to be driven, then compare.
  task automatic exp_step(input string nm, input logic [2:0] st, input logic ovr);
    exp_t e;
    e.name = nm; e.st = st; e.s1 = m_s1; e.s2 = m_s2; e.lt = m_lt;
    e.ovr = ovr; e.go = m_go; e.win = m_win;
    sb.push_back(e);
    cyc();
    compare_out();
  endtask

  // Single collision edge from one player (1 or 2); model updated by caller.
  task automatic touch_chk(input int who, input string nm);
    if (who == 1) pl1_col = 1'b1;
    else          pl2_col = 1'b1;
    exp_step(nm, S_RALLY, 1'b0);
    pl1_col = 1'b0;
    pl2_col = 1'b0;
    cyc();
  endtask

  // Remainder of the post-point pause; 'done' ticks already spent in POINT.
  task automatic wait_point(input int done);
    logic [2:0] nxt;
    tick = 1'b1;
    repeat (248 - done) cyc();
    exp_step("point_hold", S_POINT, 1'b0);
    if (m_s1 == 4'd15 || m_s2 == 4'd15) begin
      nxt   = S_OVER;
      m_go  = 1'b1;
      m_win = (m_s2 == 4'd15);
    end else begin
      nxt = S_SERVE;
    end
    exp_step("point_end", nxt, 1'b0);
    tick = 1'b0;
  endtask

  // Serve by player 1, ground contact at posx, ignored inputs during pause.
  task automatic play_point(input logic [11:0] posx, input logic p2s, input string nm);
    m_lt = 1'b0;
    touch_chk(1, "serve_touch");
    ticks(20);
    gnd_col   = 1'b1;
    ball_posx = posx;
    if (p2s) m_s2 = m_s2 + 4'd1;
    else     m_s1 = m_s1 + 4'd1;
    m_lt = p2s;
    exp_step(nm, S_POINT, 1'b0);
    gnd_col = 1'b0;
    ticks(100);
    pl1_col = 1'b1;
    gnd_col = 1'b1;
    exp_step("point_ignores_inputs", S_POINT, 1'b0);
    pl1_col = 1'b0;
    gnd_col = 1'b0;
    wait_point(100);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    vecs[0] = '{12'd700,  1'b0};
    vecs[1] = '{12'd400,  1'b1};
    vecs[2] = '{12'd479,  1'b1};
    vecs[3] = '{12'd480,  1'b0};
    vecs[4] = '{12'd0,    1'b1};
    vecs[5] = '{12'd4095, 1'b0};

    rst = 1'b1; tick = 1'b0; start = 1'b0; pl1_col = 1'b0; pl2_col = 1'b0;
    gnd_col = 1'b0; ball_posx = '0;
    m_s1 = '0; m_s2 = '0; m_lt = 1'b0; m_go = 1'b0; m_win = 1'b0;
    cyc();
    exp_step("reset_state", S_IDLE, 1'b0);
    rst = 1'b0;
    exp_step("idle_no_start", S_IDLE, 1'b0);

    start = 1'b1;
    exp_step("start_to_serve", S_SERVE, 1'b0);
    start = 1'b0;

    // Ground-contact side decision, including the net boundary and no-wrap.
    for (int i = 0; i < 6; i++)
      play_point(vecs[i].posx, vecs[i].p2_scores, $sformatf("gnd_posx_%0d", vecs[i].posx));

    // Player 1 exceeds the touch limit.
    m_lt = 1'b0;
    touch_chk(1, "ovr1_serve");
    for (int k = 0; k < 3; k++) begin
      ticks(20);
      pl1_col = 1'b1;
      if (k < 2) begin
        exp_step("ovr1_touch", S_RALLY, 1'b0);
        pl1_col = 1'b0;
        cyc();
      end else begin
        m_s2 = m_s2 + 4'd1;
        m_lt = 1'b1;
        exp_step("ovr1_fourth", S_POINT, 1'b1);
        pl1_col = 1'b0;
        exp_step("ovr1_once", S_POINT, 1'b0);
      end
    end
    wait_point(0);

    // Ghost time: edges at 5 and 17 ticks ignored, at 18 accepted.
    m_lt = 1'b0;
    touch_chk(1, "ghost_serve");
    ticks(5);
    touch_chk(2, "ghost_5");
    ticks(12);
    touch_chk(2, "ghost_17");
    ticks(1);
    m_lt = 1'b1;
    touch_chk(2, "ghost_18");
    for (int k = 0; k < 3; k++) begin
      ticks(20);
      pl2_col = 1'b1;
      if (k < 2) begin
        exp_step("ovr2_touch", S_RALLY, 1'b0);
        pl2_col = 1'b0;
        cyc();
      end else begin
        m_s1 = m_s1 + 4'd1;
        m_lt = 1'b0;
        exp_step("ovr2_fourth", S_POINT, 1'b1);
        pl2_col = 1'b0;
        exp_step("ovr2_once", S_POINT, 1'b0);
      end
    end
    wait_point(0);

    // Side change resets the count: p1,p1,p2,p1,p1,p1 then p1 overflows.
    m_lt = 1'b0;
    touch_chk(1, "sw_serve");
    ticks(20); touch_chk(1, "sw_p1_2");
    ticks(20); m_lt = 1'b1; touch_chk(2, "sw_p2_1");
    ticks(20); m_lt = 1'b0; touch_chk(1, "sw_p1_1");
    ticks(20); touch_chk(1, "sw_p1_2b");
    ticks(20); touch_chk(1, "sw_p1_3");
    ticks(20);
    pl1_col = 1'b1;
    m_s2 = m_s2 + 4'd1;
    m_lt = 1'b1;
    exp_step("sw_p1_over", S_POINT, 1'b1);
    pl1_col = 1'b0;
    cyc();
    wait_point(0);

    // Ground beats simultaneous touches.
    m_lt = 1'b0;
    touch_chk(1, "gt_serve");
    ticks(20);
    pl1_col = 1'b1; pl2_col = 1'b1; gnd_col = 1'b1; ball_posx = 12'd400;
    m_s2 = m_s2 + 4'd1;
    m_lt = 1'b1;
    exp_step("gnd_beats_touch", S_POINT, 1'b0);
    pl1_col = 1'b0; pl2_col = 1'b0; gnd_col = 1'b0;
    cyc();
    wait_point(0);

    // Ground ignored in SERVE; simultaneous serve edges go to player 1.
    gnd_col = 1'b1; ball_posx = 12'd100;
    exp_step("serve_ignores_gnd", S_SERVE, 1'b0);
    gnd_col = 1'b0;
    pl1_col = 1'b1; pl2_col = 1'b1;
    m_lt = 1'b0;
    exp_step("tie_p1_wins", S_RALLY, 1'b0);
    pl1_col = 1'b0; pl2_col = 1'b0;
    cyc();
    ticks(20);
    gnd_col = 1'b1; ball_posx = 12'd700;
    m_s1 = m_s1 + 4'd1;
    m_lt = 1'b0;
    exp_step("tie_rally_point", S_POINT, 1'b0);
    gnd_col = 1'b0;
    wait_point(0);

    // Run player 1 to the winning score.
    while (m_s1 < 4'd15)
      play_point(12'd700, 1'b0, "to_win");
    exp_step("over_holds", S_OVER, 1'b0);
    start = 1'b1;
    m_s1 = '0; m_s2 = '0; m_lt = 1'b1; m_go = 1'b0;
    exp_step("restart_serve", S_SERVE, 1'b0);
    start = 1'b0;

    // Reset during the post-point pause.
    m_lt = 1'b0;
    touch_chk(1, "rst_serve");
    ticks(20);
    gnd_col = 1'b1; ball_posx = 12'd700;
    m_s1 = m_s1 + 4'd1;
    exp_step("rst_point", S_POINT, 1'b0);
    gnd_col = 1'b0;
    ticks(100);
    rst = 1'b1;
    m_s1 = '0; m_s2 = '0; m_lt = 1'b0; m_go = 1'b0; m_win = 1'b0;
    exp_step("rst_in_point", S_IDLE, 1'b0);
    exp_step("rst_held", S_IDLE, 1'b0);
    rst = 1'b0;
    exp_step("after_rst", S_IDLE, 1'b0);
    ticks(300);
    exp_step("idle_after_rst", S_IDLE, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
